garbage_sender: RTL and testbench

Transmit side of the inter-player garbage link. Watches the local board's row-clear events, groups them into batches, converts each batch into an attack row count, and delivers rows one at a time to the opponent's `state_control` over the `send_en`/`bomb_pos` interface. It also drives the opponent's `get_line`. There is one instance per player, between the local and the opposing game controller.

---
 rtl/garbage_pkg.sv | 48 ++++
 rtl/bomb_lfsr.sv | 48 ++++
 rtl/garbage_sender.sv | 145 ++++++++++++++
 tb/tb_garbage_sender.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/garbage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : garbage_pkg
// Description : Shared types and constants for the garbage link transmit side:
//               sender FSM state encoding, attack-row lookup and LFSR taps.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef BOARD_BLOCKS_ROW
`define BOARD_BLOCKS_ROW 10
`endif

`ifndef BOARD_COL_W
`define BOARD_COL_W 4
`endif

package garbage_pkg;

    // Board dimensions follow the global board defines when they are present.
    localparam int c_blocks_row = `BOARD_BLOCKS_ROW;
    localparam int c_col_w      = `BOARD_COL_W;

    // Sender FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } send_state_t;

    // Taps for x^8 + x^6 + x^5 + x^4 + 1 (register bits 7, 5, 4, 3).
    localparam logic [7:0] c_lfsr_taps = 8'b1011_1000;

    // Largest number of row clears counted in one batch.
    localparam logic [2:0] c_batch_max = 3'd4;

    // Converts the number of rows cleared in one batch into attack rows.
    function automatic logic [2:0] attack_rows(input logic [2:0] batch);
        logic [2:0] rows;
        case (batch)
            3'd2:    rows = 3'd1;
            3'd3:    rows = 3'd2;
            3'd4:    rows = 3'd4;
            default: rows = 3'd0;
        endcase
        return rows;
    endfunction

endpackage : garbage_pkg
`default_nettype wire

// File: rtl/bomb_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : bomb_lfsr
// Description : Free-running 8-bit Fibonacci LFSR that produces a candidate
//               bomb column in 0..BLOCKS_ROW-1 every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bomb_lfsr
    import garbage_pkg::*;
#(
    parameter int         BLOCKS_ROW = 10,
    parameter int         COL_W      = 4,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [COL_W-1:0] col
);

    // One subtraction is enough because BLOCKS_ROW > 2^(COL_W-1).
    localparam logic [COL_W:0] c_limit = (COL_W + 1)'(BLOCKS_ROW);

    logic [7:0]       r_lfsr;
    logic             w_feedback;
    logic [COL_W-1:0] w_raw;

    assign w_feedback = ^(r_lfsr & c_lfsr_taps);
    assign w_raw      = r_lfsr[COL_W-1:0];

    // Shift register advances every cycle regardless of game state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    // Fold out-of-range raw values back onto the board.
    always_comb begin
        col = w_raw;
        if ({1'b0, w_raw} >= c_limit) begin
            col = w_raw - COL_W'(BLOCKS_ROW);
        end
    end

endmodule : bomb_lfsr
`default_nettype wire

// File: rtl/garbage_sender.sv
`default_nettype none
// ============================================================================
// Module      : garbage_sender
// Description : Transmit side of the inter-player garbage link. Groups local
//               row clears into batches, converts each batch into attack
//               rows and offers them one at a time to the opponent.
// Revision    : 1.0 - initial release
// ============================================================================
module garbage_sender
    import garbage_pkg::*;
#(
    parameter int         BLOCKS_ROW = c_blocks_row,
    parameter int         COL_W      = c_col_w,
    parameter int         LINE_W     = 4,
    parameter int         MAX_LINES  = 15,
    parameter int         PEND_MAX   = 15,
    parameter int         SETTLE     = 64,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              remove_row_en,
    input  logic              hold,
    input  logic              peer_ack,
    output logic              send_en,
    output logic [COL_W-1:0]  bomb_pos,
    output logic [LINE_W-1:0] get_line,
    output logic [3:0]        pending_rows
);

    localparam int                    c_settle_w    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE - 1);
    localparam logic [LINE_W-1:0]     c_line_max    = LINE_W'(MAX_LINES);
    localparam logic [5:0]            c_pend_max    = 6'(PEND_MAX);

    send_state_t           r_state;
    logic [2:0]            r_batch;
    logic [c_settle_w-1:0] r_settle;

    logic [COL_W-1:0]      w_next_col;
    logic                  w_close;
    logic                  w_ack;
    logic [2:0]            w_attack;
    logic [5:0]            w_pend_sum;
    logic [3:0]            w_pend_next;

    bomb_lfsr #(
        .BLOCKS_ROW (BLOCKS_ROW),
        .COL_W      (COL_W),
        .SEED       (SEED)
    ) u_bomb_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .col   (w_next_col)
    );

    // A new row clear in the expiry cycle extends the batch instead of closing it.
    assign w_close  = (r_batch != 3'd0) && (r_settle == c_settle_last) && !remove_row_en;
    assign w_attack = w_close ? attack_rows(r_batch) : 3'd0;
    assign w_ack    = (r_state == ST_SEND) && peer_ack;

    // Batch row counter and settle timer that decides when a batch is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batch  <= 3'd0;
            r_settle <= '0;
        end else if (clr) begin
            r_batch  <= 3'd0;
            r_settle <= '0;
        end else if (remove_row_en) begin
            r_batch  <= (r_batch >= c_batch_max) ? c_batch_max : r_batch + 3'd1;
            r_settle <= '0;
        end else if (w_close) begin
            r_batch  <= 3'd0;
            r_settle <= '0;
        end else if (r_batch != 3'd0) begin
            r_settle <= r_settle + c_settle_w'(1);
        end
    end

    // Next pending count: add closed-batch attack, remove an accepted row, then saturate.
    always_comb begin
        w_pend_sum = {2'b00, pending_rows} + {3'b000, w_attack};
        if (w_ack && (w_pend_sum != 6'd0)) begin
            w_pend_sum = w_pend_sum - 6'd1;
        end
        w_pend_next = (w_pend_sum > c_pend_max) ? 4'(PEND_MAX) : w_pend_sum[3:0];
    end

    // Pending-row and delivered-row counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_rows <= 4'd0;
            get_line     <= '0;
        end else if (clr) begin
            pending_rows <= 4'd0;
            get_line     <= '0;
        end else begin
            pending_rows <= w_pend_next;
            if (w_ack && (get_line < c_line_max)) begin
                get_line <= get_line + LINE_W'(1);
            end
        end
    end

    // Offer handshake: latch a column, hold the offer until acked, then one idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            send_en  <= 1'b0;
            bomb_pos <= '0;
        end else if (clr) begin
            r_state <= ST_IDLE;
            send_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    send_en <= 1'b0;
                    if ((pending_rows != 4'd0) && !hold) begin
                        r_state  <= ST_SEND;
                        send_en  <= 1'b1;
                        bomb_pos <= w_next_col;
                    end
                end
                ST_SEND: begin
                    if (peer_ack) begin
                        r_state <= ST_GAP;
                        send_en <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                    send_en <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    send_en <= 1'b0;
                end
            endcase
        end
    end

endmodule : garbage_sender
`default_nettype wire

// File: tb/tb_garbage_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_garbage_sender
// Description : Self-checking bench for garbage_sender. Expected delivered-row
//               counts are queued when batches close and popped on each ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_garbage_sender;

    localparam int         BLOCKS_ROW = 10;
    localparam int         COL_W      = 4;
    localparam int         LINE_W     = 4;
    localparam int         MAX_LINES  = 15;
    localparam int         PEND_MAX   = 15;
    localparam int         SETTLE     = 64;
    localparam logic [7:0] SEED       = 8'hA5;

    logic              clk           = 1'b0;
    logic              rst_n         = 1'b0;
    logic              clr           = 1'b0;
    logic              remove_row_en = 1'b0;
    logic              hold          = 1'b0;
    logic              peer_ack      = 1'b0;
    logic              send_en;
    logic [COL_W-1:0]  bomb_pos;
    logic [LINE_W-1:0] get_line;
    logic [3:0]        pending_rows;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int m_pend   = 0;
    int m_gl     = 0;

    logic [7:0] m_lfsr     = SEED;
    int         m_col_prev = 0;

    garbage_sender #(
        .BLOCKS_ROW (BLOCKS_ROW),
        .COL_W      (COL_W),
        .LINE_W     (LINE_W),
        .MAX_LINES  (MAX_LINES),
        .PEND_MAX   (PEND_MAX),
        .SETTLE     (SETTLE),
        .SEED       (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .remove_row_en (remove_row_en),
        .hold          (hold),
        .peer_ack      (peer_ack),
        .send_en       (send_en),
        .bomb_pos      (bomb_pos),
        .get_line      (get_line),
        .pending_rows  (pending_rows)
    );

    always #5 clk = ~clk;

    function automatic int ref_col(input logic [7:0] v);
        int c;
        c = int'(v[3:0]);
        if (c >= BLOCKS_ROW) c = c - BLOCKS_ROW;
        return c;
    endfunction

    function automatic int attack_of(input int n);
        case (n)
            2: return 1;
            3: return 2;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    // Reference LFSR; m_col_prev is the column the DUT could latch on the latest edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr     <= SEED;
            m_col_prev <= 0;
        end else begin
            m_col_prev <= ref_col(m_lfsr);
            m_lfsr     <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rows(input int n);
        for (int i = 0; i < n; i++) begin
            remove_row_en = 1'b1;
            tick();
            remove_row_en = 1'b0;
        end
    endtask

    // Account for a closed batch: rows beyond PEND_MAX are dropped and never delivered.
    task automatic queue_rows(input int rows);
        int room;
        int take;
        room = PEND_MAX - m_pend;
        take = (rows < room) ? rows : room;
        m_pend = m_pend + take;
        for (int i = 0; i < take; i++) begin
            if (m_gl < MAX_LINES) m_gl = m_gl + 1;
            exp_q.push_back(m_gl);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_pend = 0;
        m_gl   = 0;
        exp_q.delete();
    endtask

    // Ack the offer currently on the link and check the counters that follow.
    task automatic ack_current();
        int exp;
        peer_ack = 1'b1;
        tick();
        peer_ack = 1'b0;
        m_pend = m_pend - 1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ack_scoreboard: got an ack with no queued row, expected a queued row");
        end else begin
            exp = exp_q.pop_front();
            if (get_line !== LINE_W'(exp)) begin
                n_fail++;
                $display("FAIL ack_get_line: got %0d expected %0d", get_line, exp);
            end
        end
        n_checks++;
        if (pending_rows !== 4'(m_pend)) begin
            n_fail++;
            $display("FAIL ack_pending: got %0d expected %0d", pending_rows, m_pend);
        end
        n_checks++;
        if (send_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_send_drop: got %0b expected 0", send_en);
        end
        tick();
        n_checks++;
        if (send_en !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_send_low: got %0b expected 0", send_en);
        end
    endtask

    // Wait for each offer, check its column, hold it for ack_delay cycles, then ack.
    task automatic serve_offers(input int ack_delay, input int max_rows);
        bit seen;
        bit stayed;
        for (int r = 0; (r < max_rows) && (m_pend > 0); r++) begin
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (send_en === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL offer_timeout: got no send_en within 8 cycles, expected an offer (pending %0d)", m_pend);
                return;
            end
            n_checks++;
            if ((bomb_pos !== COL_W'(m_col_prev)) || (int'(bomb_pos) >= BLOCKS_ROW)) begin
                n_fail++;
                $display("FAIL offer_bomb_pos: got %0d expected %0d", bomb_pos, m_col_prev);
            end
            stayed = 1'b1;
            for (int i = 0; i < ack_delay; i++) begin
                tick();
                if (send_en !== 1'b1) stayed = 1'b0;
            end
            n_checks++;
            if (!stayed) begin
                n_fail++;
                $display("FAIL offer_held: got send_en drop before ack, expected level until ack");
            end
            ack_current();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (send_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_send_en: got %0b expected 0", send_en);
        end
        n_checks++;
        if (bomb_pos !== '0) begin
            n_fail++;
            $display("FAIL reset_bomb_pos: got %0d expected 0", bomb_pos);
        end
        n_checks++;
        if (get_line !== '0) begin
            n_fail++;
            $display("FAIL reset_get_line: got %0d expected 0", get_line);
        end
        n_checks++;
        if (pending_rows !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pending: got %0d expected 0", pending_rows);
        end
        rst_n = 1'b1;
    endtask

    // Two clears three cycles apart: one attack row, exact offer timing.
    task automatic test_two_pulses();
        pulse_rows(1);
        tick();
        tick();
        pulse_rows(1);
        for (int c = 1; c <= SETTLE + 1; c++) begin
            tick();
            if (c == SETTLE - 1) begin
                n_checks++;
                if (pending_rows !== 4'd0) begin
                    n_fail++;
                    $display("FAIL two_pre_close: got %0d expected 0", pending_rows);
                end
            end
            if (c == SETTLE) begin
                queue_rows(attack_of(2));
                n_checks++;
                if ((pending_rows !== 4'(m_pend)) || (send_en !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL two_close: got pending %0d send %0b expected %0d / 0", pending_rows, send_en, m_pend);
                end
            end
            if (c == SETTLE + 1) begin
                n_checks++;
                if (send_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL two_send_rise: got %0b expected 1", send_en);
                end
                n_checks++;
                if ((bomb_pos !== COL_W'(m_col_prev)) || (int'(bomb_pos) >= BLOCKS_ROW)) begin
                    n_fail++;
                    $display("FAIL two_bomb_pos: got %0d expected %0d", bomb_pos, m_col_prev);
                end
            end
        end
        ack_current();
    endtask

    task automatic test_single_pulse();
        bit rose;
        bit pend_seen;
        do_clr();
        pulse_rows(1);
        peer_ack = 1'b1;
        tick();
        peer_ack = 1'b0;
        rose = 1'b0;
        pend_seen = 1'b0;
        repeat (SETTLE + 8) begin
            tick();
            if (send_en !== 1'b0) rose = 1'b1;
            if (pending_rows !== 4'd0) pend_seen = 1'b1;
        end
        n_checks++;
        if (rose || pend_seen) begin
            n_fail++;
            $display("FAIL single_quiet: got send %0b pending_nonzero %0b expected 0 / 0", rose, pend_seen);
        end
        n_checks++;
        if (get_line !== '0) begin
            n_fail++;
            $display("FAIL single_idle_ack: got %0d expected 0", get_line);
        end
    endtask

    task automatic test_four_pulses();
        do_clr();
        pulse_rows(4);
        repeat (SETTLE) tick();
        queue_rows(attack_of(4));
        n_checks++;
        if (pending_rows !== 4'd4) begin
            n_fail++;
            $display("FAIL four_pending: got %0d expected 4", pending_rows);
        end
        serve_offers(5, 8);
        n_checks++;
        if ((get_line !== LINE_W'(4)) || (pending_rows !== 4'd0)) begin
            n_fail++;
            $display("FAIL four_done: got lines %0d pending %0d expected 4 / 0", get_line, pending_rows);
        end
    endtask

    task automatic test_hold();
        bit rose;
        bit stayed;
        do_clr();
        hold = 1'b1;
        pulse_rows(3);
        repeat (SETTLE) tick();
        queue_rows(attack_of(3));
        pulse_rows(2);
        repeat (SETTLE) tick();
        queue_rows(attack_of(2));
        n_checks++;
        if (pending_rows !== 4'd3) begin
            n_fail++;
            $display("FAIL hold_pending: got %0d expected 3", pending_rows);
        end
        rose = 1'b0;
        repeat (5) begin
            tick();
            if (send_en !== 1'b0) rose = 1'b1;
        end
        n_checks++;
        if (rose) begin
            n_fail++;
            $display("FAIL hold_blocks: got send_en 1 expected 0");
        end
        hold = 1'b0;
        tick();
        n_checks++;
        if ((send_en !== 1'b1) || (bomb_pos !== COL_W'(m_col_prev))) begin
            n_fail++;
            $display("FAIL hold_release: got send %0b pos %0d expected 1 / %0d", send_en, bomb_pos, m_col_prev);
        end
        hold = 1'b1;
        stayed = 1'b1;
        repeat (5) begin
            tick();
            if (send_en !== 1'b1) stayed = 1'b0;
        end
        n_checks++;
        if (!stayed) begin
            n_fail++;
            $display("FAIL hold_in_send: got send_en drop expected 1 until ack");
        end
        ack_current();
        rose = 1'b0;
        repeat (4) begin
            tick();
            if (send_en !== 1'b0) rose = 1'b1;
        end
        n_checks++;
        if (rose || (pending_rows !== 4'd2)) begin
            n_fail++;
            $display("FAIL hold_after_ack: got send %0b pending %0d expected 0 / 2", rose, pending_rows);
        end
        hold = 1'b0;
        serve_offers(0, 8);
        n_checks++;
        if (get_line !== LINE_W'(3)) begin
            n_fail++;
            $display("FAIL hold_done: got %0d expected 3", get_line);
        end
    endtask

    // Batch close lands on the same edge as the ack of the current offer.
    task automatic test_close_ack();
        int exp;
        do_clr();
        hold = 1'b1;
        pulse_rows(2);
        repeat (SETTLE) tick();
        queue_rows(attack_of(2));
        hold = 1'b0;
        tick();
        n_checks++;
        if (send_en !== 1'b1) begin
            n_fail++;
            $display("FAIL close_ack_offer: got %0b expected 1", send_en);
        end
        pulse_rows(3);
        repeat (SETTLE - 1) tick();
        peer_ack = 1'b1;
        tick();
        peer_ack = 1'b0;
        queue_rows(attack_of(3));
        m_pend = m_pend - 1;
        exp = exp_q.pop_front();
        n_checks++;
        if ((pending_rows !== 4'(m_pend)) || (get_line !== LINE_W'(exp)) || (send_en !== 1'b0)) begin
            n_fail++;
            $display("FAIL close_ack_same_edge: got pending %0d lines %0d send %0b expected %0d / %0d / 0",
                     pending_rows, get_line, send_en, m_pend, exp);
        end
        tick();
        serve_offers(1, 8);
        n_checks++;
        if (get_line !== LINE_W'(3)) begin
            n_fail++;
            $display("FAIL close_ack_done: got %0d expected 3", get_line);
        end
    endtask

    task automatic test_clr();
        bit seen;
        bit rose;
        do_clr();
        pulse_rows(4);
        repeat (SETTLE) tick();
        queue_rows(attack_of(4));
        serve_offers(0, 2);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (send_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || (pending_rows !== 4'd2) || (get_line !== LINE_W'(2))) begin
            n_fail++;
            $display("FAIL clr_setup: got send %0b pending %0d lines %0d expected 1 / 2 / 2", seen, pending_rows, get_line);
        end
        do_clr();
        n_checks++;
        if ((send_en !== 1'b0) || (pending_rows !== 4'd0) || (get_line !== '0)) begin
            n_fail++;
            $display("FAIL clr_flush: got send %0b pending %0d lines %0d expected 0 / 0 / 0", send_en, pending_rows, get_line);
        end
        rose = 1'b0;
        repeat (4) begin
            tick();
            if (send_en !== 1'b0) rose = 1'b1;
        end
        n_checks++;
        if (rose) begin
            n_fail++;
            $display("FAIL clr_quiet: got send_en 1 expected 0");
        end
    endtask

    task automatic test_pend_sat();
        do_clr();
        hold = 1'b1;
        for (int b = 0; b < 4; b++) begin
            pulse_rows(4);
            repeat (SETTLE) tick();
            queue_rows(attack_of(4));
            n_checks++;
            if (pending_rows !== 4'(m_pend)) begin
                n_fail++;
                $display("FAIL pend_sat_batch%0d: got %0d expected %0d", b, pending_rows, m_pend);
            end
        end
        hold = 1'b0;
        serve_offers(0, 20);
        n_checks++;
        if ((get_line !== LINE_W'(15)) || (pending_rows !== 4'd0)) begin
            n_fail++;
            $display("FAIL pend_sat_done: got lines %0d pending %0d expected 15 / 0", get_line, pending_rows);
        end
    endtask

    // Sixteen batches of four (odd batches send five clears); get_line saturates.
    task automatic test_saturation();
        do_clr();
        for (int b = 0; b < 16; b++) begin
            pulse_rows(((b % 2) == 1) ? 5 : 4);
            repeat (SETTLE) tick();
            queue_rows(4);
            n_checks++;
            if (pending_rows !== 4'(m_pend)) begin
                n_fail++;
                $display("FAIL sat_batch%0d_pending: got %0d expected %0d", b, pending_rows, m_pend);
            end
            serve_offers(0, 8);
        end
        n_checks++;
        if ((get_line !== LINE_W'(MAX_LINES)) || (pending_rows !== 4'd0)) begin
            n_fail++;
            $display("FAIL sat_done: got lines %0d pending %0d expected %0d / 0", get_line, pending_rows, MAX_LINES);
        end
    endtask

    initial begin
        test_reset();
        test_two_pulses();
        test_single_pulse();
        test_four_pulses();
        test_hold();
        test_close_ack();
        test_clr();
        test_pend_sat();
        test_saturation();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d undelivered rows expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_garbage_sender
`default_nettype wire
